// File: rtl/seq_ripple_adder_chk_pkg.sv
// adder_pkg: shared FSM state type and counter sizing for the sequential ripple adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  function automatic int cnt_w(input int ndig);
    return $clog2(ndig) + 1;
  endfunction
endpackage

// File: rtl/seq_ripple_adder_chk_if.sv
// seq_ripple_adder_chk_if: operand/result handshake bundle; fault_en exists only with FAULT_INJECT_EN
interface seq_ripple_adder_chk_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, cin, out_valid, out_ready, err, busy;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0] sum;
`ifdef FAULT_INJECT_EN
  logic fault_en;
  modport slave(input in_valid, a, b, cin, out_ready, fault_en, output in_ready, out_valid, sum, err, busy);
  modport master(output in_valid, a, b, cin, out_ready, fault_en, input in_ready, out_valid, sum, err, busy);
`else
  modport slave(input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, err, busy);
  modport master(output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, err, busy);
`endif
endinterface

// File: rtl/seq_ripple_adder_chk_full_adder_slice.sv
// full_adder_slice: DIGIT chained full-adder cells forming one ripple digit
module full_adder_slice #(parameter int DIGIT = 1) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);
  logic [DIGIT:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[DIGIT];
endmodule

// File: rtl/seq_ripple_adder_chk.sv
// seq_ripple_adder_chk: digit-serial ripple adder with golden-sum checker; FAULT_INJECT_EN adds sum-bit fault injection
module seq_ripple_adder_chk
  import adder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIGIT     = 1,
  parameter int FAULT_BIT = 1
) (
  input logic                  clk,
  input logic                  rst,
  seq_ripple_adder_chk_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_w(NDIG);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0] golden, sum_q;
  logic carry, ov, err_q, s_cout, last;
  logic [DIGIT-1:0] s_out, s_wr;
  full_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a(a_q[cnt*DIGIT +: DIGIT]),
    .b(b_q[cnt*DIGIT +: DIGIT]),
    .cin(carry),
    .sum(s_out),
    .cout(s_cout)
  );
  assign last = cnt == CW'(NDIG - 1);
`ifdef FAULT_INJECT_EN
  logic fault_q;
  // only the written sum bit is flipped; s_cout keeps the carry chain clean
  assign s_wr = s_out ^ ((fault_q && cnt == CW'(FAULT_BIT / DIGIT)) ? DIGIT'(1) << (FAULT_BIT % DIGIT) : '0);
`else
  assign s_wr = s_out;
`endif
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.in_valid ? ADD : IDLE) :
              state == ADD  ? (last ? DONE : ADD) :
              (ov && bus.out_ready) ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      golden <= '0;
      sum_q  <= '0;
      ov     <= 1'b0;
      err_q  <= 1'b0;
`ifdef FAULT_INJECT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        a_q    <= bus.a;
        b_q    <= bus.b;
        carry  <= bus.cin;
        golden <= {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(bus.cin);
        cnt    <= '0;
        sum_q  <= '0;
`ifdef FAULT_INJECT_EN
        fault_q <= bus.fault_en;
`endif
      end
      if (state == ADD) begin
        sum_q[cnt*DIGIT +: DIGIT] <= s_wr;
        carry <= s_cout;
        cnt   <= cnt + 1'b1;
        if (last) sum_q[WIDTH] <= s_cout;
      end
      // first DONE cycle registers the compare, so out_valid and err rise together
      if (state == DONE) begin
        ov    <= !(ov && bus.out_ready);
        err_q <= sum_q != golden;
      end
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.out_valid = ov;
  assign bus.sum       = sum_q;
  assign bus.err       = err_q;
endmodule
